fgen_sweep_sequencer: RTL and testbench
=======================================

Name: fgen_sweep_sequencer

Overview:
Programmable sequencer that drives the control inputs of the FuntionGenerator top (wave_select, gears, rstn) from a small segment table.
Each segment is a (waveform, gear, dwell) triple. The sequencer plays segments 0..last in order, with an output-off gap between them, and optionally loops.
It sits between the board/host configuration logic and FuntionGenerator, in the clk_50MHz domain. Dwell is counted in clk_50MHz cycles.

Parameters:
NUM_SEG, 8, number of table entries (power of 2, >=2)
SEG_W, 3, log2(NUM_SEG)
DWELL_W, 24, dwell counter width
GAP_CYCLES, 4, cycles gen_rstn is held low in GAP state (>=1)

Ports:
clk_50MHz  in  1  system clock
rst  in  1  synchronous, active-high reset
cfg_we  in  1  table write strobe
cfg_addr  in  SEG_W  table entry index
cfg_wave  in  2  waveform code for entry
cfg_gears  in  2  gear code for entry
cfg_dwell  in  DWELL_W  dwell length, cycles; 0 treated as 1
last_seg  in  SEG_W  index of final segment, sampled at start
loop_en  in  1  1 = restart at seg 0 after last_seg, sampled at start
start  in  1  begin sequence (level-sampled in IDLE)
abort  in  1  stop immediately
wave_select  out  2  to FuntionGenerator.wave_select
gears  out  2  to FuntionGenerator.gears
gen_rstn  out  1  to FuntionGenerator.rstn; 1 = generator running
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at normal sequence completion
cur_seg  out  SEG_W  index of segment currently loaded

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge):
  - state=IDLE; all outputs 0 (gen_rstn=0).
  - Table contents cleared to 0 (wave 0, gears 0, dwell 0).
- States:
  - IDLE: hold wave_select, gears and cur_seg from the last run.
    - start=1 -> SETUP; latch last_seg and loop_en; seg=0.
  - SETUP (1 cycle): wave_select, gears and cur_seg take entry[seg]; gen_rstn=0.
    - Next state DWELL; cnt=max(dwell,1).
  - DWELL: gen_rstn=1; cnt decrements each cycle.
    - When cnt==1: seg==last and loop_en=0 -> FINISH.
    - Otherwise -> GAP. The next seg is seg+1, or 0 if seg==last.
  - GAP: gen_rstn=0 for exactly GAP_CYCLES cycles, then SETUP with the next seg.
  - FINISH (1 cycle): done=1, gen_rstn=0, then IDLE.
- Timing:
  - start sampled at edge E0 -> SETUP values visible after E0.
  - gen_rstn rises after E1 and stays high exactly max(dwell,1) cycles.
  - Inter-segment low time = GAP_CYCLES+1 cycles (GAP + SETUP).
- last_seg/loop_en changes while busy have no effect.
- Table writes:
  - cfg_we writes while IDLE.
  - cfg_we while busy is ignored; the table is unchanged.
  - A write and start in the same cycle: the write lands, and SETUP reads the new value.
- abort=1 in any state:
  - Next state IDLE; gen_rstn=0 next cycle; done not pulsed.
  - wave_select/gears/cur_seg hold.
  - abort has priority over start, and over all DWELL/GAP transitions.
- rst has priority over abort.
- last_seg=0: single-segment run; with loop_en the segment repeats through GAP.
- cnt width DWELL_W; max dwell 2^DWELL_W-1; no wrap occurs.

Decomposition:
- Package fgen_pkg:
  - state enum {IDLE, SETUP, DWELL, GAP, FINISH}.
  - Waveform/gear code widths (2).
  - Segment record type {wave, gears, dwell}.
- Sub-module fgen_seg_table: NUM_SEG-entry register file.
  - Synchronous write with a write-enable gated by ~busy.
  - Combinational read by index.
- FSM, dwell counter and gap counter live in fgen_sweep_sequencer.

Test Plan:
1. Reset, then check outputs and table.
   - Stimulus: rst=1 for 2 cycles.
   - Response: all outputs 0; table reads 0.
2. Two-segment run.
   - Stimulus: write seg0={wave 1, gears 2, dwell 5} and seg1={wave 3, gears 0, dwell 3}; last_seg=1, loop_en=0, start pulse.
   - Response: gen_rstn high 5 cycles with wave_select=1/gears=2; then low 5 cycles; then high 3 cycles with 3/0; done pulses once; busy falls the cycle after done.
3. Loop with zero dwell.
   - Stimulus: seg0 dwell=0, last_seg=0, loop_en=1.
   - Response: gen_rstn pattern is 1 high, 5 low, repeating; done never asserts.
4. Abort mid-DWELL.
   - Stimulus: abort at cycle 3 of a dwell of 10.
   - Response: gen_rstn=0 and busy=0 next cycle; done=0; cur_seg holds.
5. Write while busy.
   - Stimulus: cfg_we to seg0 during DWELL.
   - Response: the following run uses the original seg0 values.
6. Reset mid-GAP.
   - Stimulus: rst=1 during GAP.
   - Response: state IDLE; outputs 0; table cleared; start afterwards runs with dwell 1 per segment.

Source files
------------

// File: rtl/fgen_pkg.sv
// Shared types for the function-generator sweep sequencer.
//   wave_t / gears_t : control codes forwarded to FuntionGenerator
//   dwell_t          : dwell length in clk_50MHz cycles
//   seg_t            : one segment table entry {wave, gears, dwell}
//   state_t          : sequencer FSM states
package fgen_pkg;

  localparam int WAVE_W  = 2;
  localparam int GEARS_W = 2;
  localparam int DWELL_W = 24;

  typedef logic [WAVE_W-1:0]  wave_t;
  typedef logic [GEARS_W-1:0] gears_t;
  typedef logic [DWELL_W-1:0] dwell_t;

  typedef struct packed {
    wave_t  wave;
    gears_t gears;
    dwell_t dwell;
  } seg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DWELL,
    ST_GAP,
    ST_FINISH
  } state_t;

  // A programmed dwell of 0 still runs the generator for one cycle.
  function automatic dwell_t dwell_eff(input dwell_t d);
    return (d == '0) ? dwell_t'(1) : d;
  endfunction

endpackage

// File: rtl/fgen_seg_table.sv
// Segment table: NUM_SEG entries of {wave, gears, dwell}.
//   clk_50MHz, rst : clock, synchronous active-high clear of every entry
//   we, busy       : write strobe; writes are dropped while busy is high
//   waddr, wdata   : write index and entry value
//   raddr, rdata   : combinational read port
module fgen_seg_table
  import fgen_pkg::*;
#(
  parameter int NUM_SEG = 8,
  parameter int SEG_W   = 3
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             we,
  input  logic             busy,
  input  logic [SEG_W-1:0] waddr,
  input  seg_t             wdata,
  input  logic [SEG_W-1:0] raddr,
  output seg_t             rdata
);

  seg_t entry [NUM_SEG];

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        entry[i] <= '0;
      end
    end else if (we && !busy) begin
      entry[waddr] <= wdata;
    end
  end

  assign rdata = entry[raddr];

endmodule

// File: rtl/fgen_sweep_sequencer.sv
// Sweep sequencer driving FuntionGenerator's wave_select/gears/rstn from a
// segment table. Segments 0..last_seg play in order with an output-off gap
// between them, optionally looping.
//   clk_50MHz, rst         : clock, synchronous active-high reset
//   cfg_we/addr/wave/
//   cfg_gears/cfg_dwell    : table write port (accepted only while idle)
//   last_seg, loop_en      : run shape, captured when a run starts
//   start, abort           : begin a run (sampled in IDLE) / stop at once
//   wave_select, gears,
//   gen_rstn               : generator controls (gen_rstn=1 -> running)
//   busy, done, cur_seg    : status; done pulses on normal completion
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; generator held off, codes hold last run
// ST_SETUP  | codes of current segment loaded, generator still off
// ST_DWELL  | generator running, dwell counter counting down to 1
// ST_GAP    | generator off for GAP_CYCLES between segments
// ST_FINISH | one-cycle done pulse, then back to IDLE
module fgen_sweep_sequencer
  import fgen_pkg::*;
#(
  parameter int NUM_SEG    = 8,
  parameter int SEG_W      = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SEG_W-1:0]   cfg_addr,
  input  logic [WAVE_W-1:0]  cfg_wave,
  input  logic [GEARS_W-1:0] cfg_gears,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [SEG_W-1:0]   last_seg,
  input  logic               loop_en,
  input  logic               start,
  input  logic               abort,
  output logic [WAVE_W-1:0]  wave_select,
  output logic [GEARS_W-1:0] gears,
  output logic               gen_rstn,
  output logic               busy,
  output logic               done,
  output logic [SEG_W-1:0]   cur_seg
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t             state_q, state_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [SEG_W-1:0]   last_q, last_d;
  logic               loop_q, loop_d;
  dwell_t             cnt_q, cnt_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  wave_t              wave_d;
  gears_t             gears_d;
  logic [SEG_W-1:0]   cur_seg_d;
  logic               load;

  seg_t               wr_seg, rd_seg, ld_seg;
  logic [SEG_W-1:0]   raddr;

  assign wr_seg = '{wave: cfg_wave, gears: cfg_gears, dwell: cfg_dwell};
  assign raddr  = (state_q == ST_IDLE) ? '0 : seg_q;

  fgen_seg_table #(
    .NUM_SEG(NUM_SEG),
    .SEG_W  (SEG_W)
  ) u_table (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .we       (cfg_we),
    .busy     (busy),
    .waddr    (cfg_addr),
    .wdata    (wr_seg),
    .raddr    (raddr),
    .rdata    (rd_seg)
  );

  // A write to entry 0 on the start edge lands in the table on that same
  // edge, so the codes latched into SETUP are taken from the write data.
  always_comb begin
    ld_seg = rd_seg;
    if (state_q == ST_IDLE && cfg_we && cfg_addr == '0) begin
      ld_seg = wr_seg;
    end
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    last_d    = last_q;
    loop_d    = loop_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    wave_d    = wave_select;
    gears_d   = gears;
    cur_seg_d = cur_seg;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          seg_d   = '0;
          last_d  = last_seg;
          loop_d  = loop_en;
          load    = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d = ST_DWELL;
        cnt_d   = dwell_eff(rd_seg.dwell);
      end
      ST_DWELL: begin
        if (cnt_q == dwell_t'(1)) begin
          if (seg_q == last_q && !loop_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_GAP;
            gcnt_d  = GAP_W'(GAP_CYCLES);
            seg_d   = (seg_q == last_q) ? '0 : seg_q + SEG_W'(1);
          end
        end else begin
          cnt_d = cnt_q - dwell_t'(1);
        end
      end
      ST_GAP: begin
        if (gcnt_q == GAP_W'(1)) begin
          state_d = ST_SETUP;
          load    = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      load    = 1'b0;
    end

    if (load) begin
      wave_d    = ld_seg.wave;
      gears_d   = ld_seg.gears;
      cur_seg_d = seg_d;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seg_q       <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      wave_select <= '0;
      gears       <= '0;
      cur_seg     <= '0;
      gen_rstn    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      wave_select <= wave_d;
      gears       <= gears_d;
      cur_seg     <= cur_seg_d;
      gen_rstn    <= (state_d == ST_DWELL);
      busy        <= (state_d != ST_IDLE);
      done        <= (state_d == ST_FINISH);
    end
  end

endmodule

// File: tb/tb_fgen_sweep_sequencer.sv
module tb_fgen_sweep_sequencer;
  import fgen_pkg::*;

  localparam int NUM_SEG = 8;
  localparam int SEG_W   = 3;
  localparam int GAP     = 4;
  localparam int LIMIT   = 150;

  logic               clk_50MHz = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [SEG_W-1:0]   cfg_addr = '0;
  logic [1:0]         cfg_wave = '0;
  logic [1:0]         cfg_gears = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [SEG_W-1:0]   last_seg = '0;
  logic               loop_en = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [1:0]         wave_select;
  logic [1:0]         gears;
  logic               gen_rstn;
  logic               busy;
  logic               done;
  logic [SEG_W-1:0]   cur_seg;

  always #10 clk_50MHz = ~clk_50MHz;

  fgen_sweep_sequencer #(
    .NUM_SEG   (NUM_SEG),
    .SEG_W     (SEG_W),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wave   (cfg_wave),
    .cfg_gears  (cfg_gears),
    .cfg_dwell  (cfg_dwell),
    .last_seg   (last_seg),
    .loop_en    (loop_en),
    .start      (start),
    .abort      (abort),
    .wave_select(wave_select),
    .gears      (gears),
    .gen_rstn   (gen_rstn),
    .busy       (busy),
    .done       (done),
    .cur_seg    (cur_seg)
  );

  typedef struct packed {
    logic             rstn;
    logic             busy;
    logic             done;
    logic [1:0]       wave;
    logic [1:0]       gears;
    logic [SEG_W-1:0] seg;
  } obs_t;

  int unsigned m_wave [NUM_SEG];
  int unsigned m_gears[NUM_SEG];
  int unsigned m_dwell[NUM_SEG];
  obs_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample_obs();
    obs_t o;
    o.rstn  = gen_rstn;
    o.busy  = busy;
    o.done  = done;
    o.wave  = wave_select;
    o.gears = gears;
    o.seg   = cur_seg;
    return o;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_SEG; i++) begin
      m_wave[i] = 0; m_gears[i] = 0; m_dwell[i] = 0;
    end
  endfunction

  // Expected per-cycle outputs of a run, first entry = cycle after start edge.
  task automatic build_trace(input int last, input bit lp);
    int   s;
    int   d;
    obs_t o;
    exp_q.delete();
    s = 0;
    forever begin
      d = (m_dwell[s] == 0) ? 1 : int'(m_dwell[s]);
      o.wave = 2'(m_wave[s]); o.gears = 2'(m_gears[s]); o.seg = SEG_W'(s);
      o.busy = 1'b1; o.done = 1'b0; o.rstn = 1'b0;
      exp_q.push_back(o);
      o.rstn = 1'b1;
      repeat (d) exp_q.push_back(o);
      o.rstn = 1'b0;
      if (s == last && !lp) begin
        o.done = 1'b1; exp_q.push_back(o);
        o.done = 1'b0; o.busy = 1'b0; exp_q.push_back(o);
        break;
      end
      repeat (GAP) exp_q.push_back(o);
      s = (s == last) ? 0 : s + 1;
      if (exp_q.size() >= LIMIT) break;
    end
  endtask

  task automatic write_seg(input int a, input int w, input int g, input int d);
    @(negedge clk_50MHz);
    cfg_we = 1'b1; cfg_addr = SEG_W'(a); cfg_wave = 2'(w); cfg_gears = 2'(g);
    cfg_dwell = DWELL_W'(d);
    m_wave[a] = w; m_gears[a] = g; m_dwell[a] = d;
    @(negedge clk_50MHz);
    cfg_we = 1'b0;
  endtask

  // stop_kind: 0 run to natural end, 1 abort after entry stop_at, 2 reset after it.
  task automatic run_seq(input string name, input int last, input bit lp,
                         input int stop_kind, input int stop_at,
                         input bit noise, input bit same_wr);
    int   n;
    int   kind;
    int   a;
    obs_t held;
    obs_t idle_o;
    @(negedge clk_50MHz);
    start = 1'b1; last_seg = SEG_W'(last); loop_en = lp;
    if (same_wr) begin
      a = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, NUM_SEG - 1));
      cfg_we = 1'b1; cfg_addr = SEG_W'(a);
      cfg_wave = 2'($urandom); cfg_gears = 2'($urandom);
      cfg_dwell = DWELL_W'($urandom_range(0, 5));
      m_wave[a] = cfg_wave; m_gears[a] = cfg_gears; m_dwell[a] = int'(cfg_dwell);
    end
    build_trace(last, lp);
    kind = stop_kind;
    n = exp_q.size();
    if (kind != 0 && stop_at < n) n = stop_at + 1;
    else if (exp_q[n-1].busy) kind = 1;
    else kind = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50MHz);
      check_eq($sformatf("%s cyc%0d", name, i), 32'(sample_obs()), 32'(exp_q[i]));
      start = 1'b0;
      last_seg = SEG_W'($urandom); loop_en = 1'($urandom);
      cfg_we = noise && exp_q[i].busy && ($urandom_range(0, 2) == 0);
      cfg_addr = SEG_W'($urandom); cfg_wave = 2'($urandom);
      cfg_gears = 2'($urandom); cfg_dwell = DWELL_W'($urandom);
      abort = (i == n - 1) && (kind == 1);
      rst   = (i == n - 1) && (kind == 2);
    end
    if (kind != 0) begin
      held = exp_q[n-1];
      @(negedge clk_50MHz);
      idle_o = '0;
      if (kind == 1) begin
        idle_o.wave = held.wave; idle_o.gears = held.gears; idle_o.seg = held.seg;
      end else begin
        model_clear();
      end
      check_eq($sformatf("%s stop", name), 32'(sample_obs()), 32'(idle_o));
      abort = 1'b0; rst = 1'b0;
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    int last;
    model_clear();
    // Reset state, held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    check_eq("reset", 32'(sample_obs()), 32'(obs_t'('0)));
    rst = 1'b0;
    // Cleared table: every segment runs with wave 0, gears 0, dwell 1
    run_seq("cleared", NUM_SEG - 1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Two-segment run
    write_seg(0, 1, 2, 5);
    write_seg(1, 3, 0, 3);
    run_seq("two_seg", 1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Looping single segment with zero dwell
    write_seg(0, 2, 1, 0);
    run_seq("loop0", 0, 1'b1, 0, 0, 1'b0, 1'b0);

    // Abort at the third dwell cycle of a 10-cycle dwell
    write_seg(0, 3, 3, 10);
    run_seq("abort", 0, 1'b0, 1, 3, 1'b0, 1'b0);

    // Writes during a run are ignored; the next run still sees the old table
    write_seg(0, 1, 1, 4);
    write_seg(1, 2, 3, 2);
    run_seq("wr_busy", 1, 1'b0, 0, 0, 1'b1, 1'b0);
    run_seq("wr_after", 1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Write and start on the same edge
    run_seq("wr_start", 1, 1'b0, 0, 0, 1'b0, 1'b1);

    // Reset during GAP, then a run over the cleared table
    write_seg(0, 1, 2, 2);
    write_seg(1, 3, 1, 2);
    run_seq("rst_gap", 1, 1'b0, 2, 4, 1'b0, 1'b0);
    run_seq("post_rst", 3, 1'b0, 0, 0, 1'b0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) begin
        write_seg(int'($urandom_range(0, NUM_SEG - 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      end
      last = int'($urandom_range(0, NUM_SEG - 1));
      case ($urandom_range(0, 3))
        0: run_seq($sformatf("rnd%0d", r), last, 1'($urandom), 1,
                   int'($urandom_range(0, 40)), 1'b1, 1'($urandom));
        1: run_seq($sformatf("rnd%0d", r), last, 1'($urandom), 2,
                   int'($urandom_range(0, 40)), 1'b1, 1'($urandom));
        default: run_seq($sformatf("rnd%0d", r), last, 1'($urandom), 0, 0,
                         1'b1, 1'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
